superscalar_inst_queue: RTL
===========================

SUPERSCALAR_INST_QUEUE -- requirements
Module: superscalar_inst_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 395, bits per entry (one decoded instruction).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, at least 2*SS.
REQ-003 SHALL have parameter SS, default 2, superscalar width (push/pop lanes); 1 to 4.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port flush, input, 1, discards all entries (branch mispredict recovery).
REQ-007 SHALL have port in, input, SS x WIDTH, push lanes; lane 0 is oldest.
REQ-008 SHALL have port push_cnt, input, $clog2(SS+1), number of lanes to push, lanes 0..push_cnt-1.
REQ-009 SHALL have port push_ok, output, 1, high when free >= push_cnt this cycle.
REQ-010 SHALL have port out, output, SS x WIDTH, entries head..head+SS-1; lane 0 is oldest.
REQ-011 SHALL have port out_valid, output, SS, bit i high iff count > i.
REQ-012 SHALL have port pop_cnt, input, $clog2(SS+1), number of lanes consumed.
REQ-013 SHALL have ports count and free, output, $clog2(DEPTH+1) each, occupancy and free slots.
REQ-014 SHALL have ports full and empty, output, 1 each: full = (free < SS); empty = (count == 0).

Function
REQ-015 Push SHALL be all-or-nothing: when push_ok=1, push_cnt entries are written at tail..tail+push_cnt-1; when push_ok=0, nothing is written.
REQ-016 push_ok and free SHALL use the registered count only; same-cycle pops SHALL NOT create push space.
REQ-017 Effective pop SHALL be min(pop_cnt, count); excess pop requests SHALL be ignored without error.
REQ-018 Push and pop in the same cycle SHALL both take effect: count_next = count + accepted_push - effective_pop.
REQ-019 Head and tail SHALL advance modulo DEPTH; multi-lane writes and reads that straddle index DEPTH-1 SHALL wrap to 0.
REQ-020 out SHALL be read combinationally from registered storage. An entry pushed in cycle N SHALL appear on out in cycle N+1 at the earliest (no write-through bypass).
REQ-021 out lanes with out_valid=0 SHALL carry don't-care data.
REQ-022 flush SHALL set head=tail=count=0 in the next cycle, with priority over push and pop in the same cycle. Storage contents need not be cleared.
REQ-023 push_cnt=0 and pop_cnt=0 SHALL leave state unchanged.
REQ-024 count SHALL never exceed DEPTH and never underflow, under any input sequence.

Reset
REQ-025 rst SHALL take priority over flush, push and pop.
REQ-026 After reset: head=0, tail=0, count=0, free=DEPTH, empty=1, full=0, out_valid=0, push_ok=1.
REQ-027 Reset asserted mid-operation SHALL discard all entries in one cycle; storage need not be cleared.

Structure
REQ-028 SS, the default DEPTH and the entry typedef SHALL live in the shared rv32i_types package; the entry typedef is the instruction_info_reg_t megaword.
REQ-029 No sub-module is needed. Storage, pointers and counters SHALL be inline, with one always_ff and one always_comb for next-state logic.
REQ-030 The block SHALL replace the two_inst_buff plus circular_queue pair between decode and dispatch.

Verification (DEPTH=8, SS=2, WIDTH=32)
REQ-031 Reset, then push_cnt=2 with in={A,B} -> next cycle count=2, out={A,B}, out_valid=2'b11.
REQ-032 Fill to count=7, then push_cnt=2 -> push_ok=0, count stays 7, full=1; then push_cnt=1 -> count=8, free=0.
REQ-033 Advance head to 7, push {C,D}, pop 2 -> C read from index 7, D from index 0, in order; count returns to 0.
REQ-034 count=1, pop_cnt=2 -> count=0, empty=1, with no underflow.
REQ-035 count=4, same cycle push_cnt=2, pop_cnt=2, flush=1 -> next cycle count=0, empty=1, push_ok=1.
REQ-036 count=6, pop_cnt=2 and push_cnt=2 in the same cycle -> push_ok=1, count stays 6. With count=7 and the same stimulus -> push rejected, count=5.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: types and sizing shared by the decode/dispatch front end.
// The decoded-instruction megaword is what the instruction queue carries.
package rv32i_types;

    localparam int SUPERSCALAR  = 2;
    localparam int INST_Q_DEPTH = 16;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] inst;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] imm;
        logic [31:0] i_imm;
        logic [31:0] s_imm;
        logic [31:0] b_imm;
        logic [31:0] u_imm;
        logic [31:0] j_imm;
        logic [3:0]  alu_op;
        logic [2:0]  cmp_op;
        logic [3:0]  ctrl;
    } instruction_info_reg_t;

    localparam int INST_INFO_W = $bits(instruction_info_reg_t);

endpackage

// File: rtl/superscalar_inst_queue.sv
// superscalar_inst_queue: multi-lane circular instruction queue between decode and dispatch.
// Pushes are all-or-nothing against the registered count; pops saturate at the occupancy.
module superscalar_inst_queue
    import rv32i_types::*;
#(
    parameter int WIDTH = INST_INFO_W,
    parameter int DEPTH = INST_Q_DEPTH,
    parameter int SS    = SUPERSCALAR
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [SS-1:0][WIDTH-1:0]      in,
    input  logic [$clog2(SS+1)-1:0]       push_cnt,
    output logic                          push_ok,
    output logic [SS-1:0][WIDTH-1:0]      out,
    output logic [SS-1:0]                 out_valid,
    input  logic [$clog2(SS+1)-1:0]       pop_cnt,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [$clog2(DEPTH+1)-1:0]    free,
    output logic                          full,
    output logic                          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head, tail, head_next, tail_next;
    logic [CW-1:0]    count_next, push_acc, pop_eff;

    assign free    = CW'(DEPTH) - count;
    assign push_ok = free >= CW'(push_cnt);
    assign full    = free < CW'(SS);
    assign empty   = count == '0;

    // Pointer arithmetic wraps for free because DEPTH is a power of two.
    always_comb begin
        push_acc   = push_ok ? CW'(push_cnt) : '0;
        pop_eff    = CW'(pop_cnt) < count ? CW'(pop_cnt) : count;
        head_next  = head + PW'(pop_eff);
        tail_next  = tail + PW'(push_acc);
        count_next = count + push_acc - pop_eff;
        if (rst || flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        head  <= head_next;
        tail  <= tail_next;
        count <= count_next;
        for (int i = 0; i < SS; i++)
            if (!rst && !flush && push_ok && i < int'(push_cnt))
                mem[tail + PW'(i)] <= in[i];
    end

    for (genvar g = 0; g < SS; g++) begin : g_out
        assign out[g]       = mem[head + PW'(g)];
        assign out_valid[g] = count > CW'(g);
    end

endmodule
